simmem_wdata_binder: RTL and testbench
======================================

// Module: simmem_wdata_binder
// PURPOSE
// - Parametrised write-data/write-address reconciler between the requester and the delay calculator core.
// - Binds every write data beat to the write burst (IID) it belongs to, in AXI order.
//   - Beats that arrive before their address are credited to that address as an immediate count.
//   - Later beats are forwarded tagged with the IID of the oldest unfinished burst.
// - Bounded: the early-beat counter and the pending-burst queue stall the requester instead of overflowing.
// PARAMETERS
// - MaxEarlyBeats  64  maximum number of held beats with no address yet; power of two
// - AddrQueueDepth 8   number of accepted bursts still awaiting data; power of two, >=2
// - BurstLenW      8   width of the AXI burst_len field; effective length = burst_len+1
// - IidW           3   width of the internal write identifier
// PORTS
// - clk_i                      in  1                clock
// - rst_i                      in  1                synchronous active-high reset
// - waddr_valid_i              in  1                write address valid from requester
// - waddr_ready_o              out 1                write address accepted
// - waddr_burst_len_i          in  BurstLenW        AXI burst_len
// - waddr_iid_i                in  IidW             IID from the write response bank
// - wdata_valid_i              in  1                write data beat valid
// - wdata_ready_o              out 1                write data beat accepted
// - core_waddr_valid_o         out 1                address to core (same cycle as acceptance)
// - core_waddr_ready_i         in  1                core has a write slot
// - core_waddr_iid_o           out IidW             = waddr_iid_i
// - core_waddr_len_o           out BurstLenW+1      effective burst length
// - core_wdata_immediate_cnt_o out BurstLenW+1      beats already held for this burst
// - core_wdata_valid_o         out 1                late beat to core, single-cycle pulse
// - core_wdata_iid_o           out IidW             IID owning the late beat
// - core_wdata_last_o          out 1                late beat completes its burst
// - wdata_stall_cnt_o          out 16               stall statistics (see CONFIGURATION)
// BEHAVIOUR
// - State:
//   - early_q: unsigned counter, 0..MaxEarlyBeats.
//   - Pending FIFO of {iid, remaining}; the head's remaining field is decremented in place.
//   - Invariant: early_q>0 implies FIFO empty.
// - While rst_i is high, all ready/valid outputs are 0. The cycle after release, state is empty and counters are 0.
// - waddr_ready_o = core_waddr_ready_i && !fifo_full_q. No same-cycle pop bypass.
// - core_waddr_valid_o = waddr_valid_i && !fifo_full_q.
// - wdata_ready_o = fifo_nonempty_q || (early_q < MaxEarlyBeats).
// - Accepted beat with FIFO non-empty:
//   - core_wdata_valid_o=1 with the head IID.
//   - core_wdata_last_o = (head.remaining==1).
//   - Decrement head.remaining; pop the head when it reaches 0.
// - Accepted beat with FIFO empty: the beat goes to the early count (e = early_q+1); nothing is forwarded.
// - Accepted address:
//   - imm = min(e, len), where e already includes a same-cycle early beat.
//   - early_d = e-imm.
//   - If len>imm, push {iid, len-imm}.
//   - core_wdata_immediate_cnt_o = imm, combinational.
// - Address and beat in the same cycle with FIFO non-empty: the beat serves the old head and the new burst is pushed behind it. Push and pop in one cycle are legal.
// - Pointers wrap modulo AddrQueueDepth.
// - A full FIFO stalls addresses only. At early_q==MaxEarlyBeats with FIFO empty, data stalls until an address arrives.
// - No registered latency on any output; all outputs are derived combinationally from the current state and inputs.
// CONFIGURATION
// - SIMMEM_WDATA_STALL_CNT_EN defined:
//   - wdata_stall_cnt_o counts cycles with wdata_valid_i && !wdata_ready_o.
//   - Saturates at 16'hFFFF; cleared by rst_i.
// - SIMMEM_WDATA_STALL_CNT_EN undefined: wdata_stall_cnt_o is tied to '0 and no counter flops exist.
// STRUCTURE
// - In simmem_pkg:
//   - Localparams for the default BurstLenW and IidW.
//   - Typedef wdata_pend_t {iid, remaining}.
//   - Function get_effective_burst_len (reused).
// - Sub-module simmem_wdata_pend_fifo:
//   - Synchronous FIFO of wdata_pend_t.
//   - Head-entry decrement port; full/empty flags.
// TESTING
// - Address len=3 (4 beats), no prior data -> imm=0. 4 beats forwarded with iid; last=1 only on the 4th.
// - 6 early beats, then address len=3 -> imm=4, early_q=2. Next address len=1 -> imm=2, early_q=0, no push.
// - early_q=0, FIFO empty, address len=0 and beat in the same cycle -> imm=1, nothing pushed, core_wdata_valid_o=0.
// - 64 early beats -> wdata_ready_o=0. Address len=7 -> ready returns next cycle, early_q=56.
// - 8 bursts of len=0 accepted, no data -> waddr_ready_o=0. One beat pops -> next address accepted the following cycle.
// - rst_i asserted mid-burst (head remaining=2) -> FIFO empty and early_q=0. With the macro defined, stall count is 0.

Source files
------------

// File: rtl/simmem_pkg.sv
// ============================================================================
// Module      : simmem_pkg
// Description : Shared types, default widths and helpers for the simulated
//               memory write-data path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simmem_pkg;

    // Default widths of the AXI burst_len field and of the internal write ID.
    localparam int SIMMEM_BURST_LEN_W = 8;
    localparam int SIMMEM_IID_W       = 3;

    // One pending write burst: its IID and the number of beats still owed.
    typedef struct packed {
        logic [SIMMEM_IID_W-1:0]     iid;
        logic [SIMMEM_BURST_LEN_W:0] remaining;
    } wdata_pend_t;

    // AXI encodes a burst of N beats as N-1; widen by one bit so 256 fits.
    function automatic logic [SIMMEM_BURST_LEN_W:0] get_effective_burst_len(
        input logic [SIMMEM_BURST_LEN_W-1:0] burst_len
    );
        return {1'b0, burst_len} + {{SIMMEM_BURST_LEN_W{1'b0}}, 1'b1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/simmem_wdata_pend_fifo.sv
// ============================================================================
// Module      : simmem_wdata_pend_fifo
// Description : Synchronous FIFO of pending write bursts. The head entry's
//               remaining-beat field can be decremented in place.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simmem_wdata_pend_fifo
    import simmem_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  wdata_pend_t push_data_i,
    input  logic        dec_i,
    input  logic        pop_i,
    output wdata_pend_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = $clog2(Depth);
    localparam int CNT_W = $clog2(Depth + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(Depth);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    wdata_pend_t      mem_q [Depth];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);

    // Pointer and occupancy bookkeeping; pointers wrap since Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    // Entry storage: write at the tail, count down the head unless it leaves.
    // Tail and head only coincide when empty (no dec) or full (no push).
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
        if (dec_i && !pop_i) begin
            mem_q[rptr_q].remaining <= mem_q[rptr_q].remaining - {{SIMMEM_BURST_LEN_W{1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/simmem_wdata_binder.sv
// ============================================================================
// Module      : simmem_wdata_binder
// Description : Binds each write data beat to its write burst (IID) in AXI
//               order. Beats that precede their address are credited to it as
//               an immediate count; later beats are forwarded tagged with the
//               IID of the oldest unfinished burst.
// Options     : SIMMEM_WDATA_STALL_CNT_EN - enables the 16-bit saturating
//               counter of stalled data cycles on wdata_stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simmem_wdata_binder
    import simmem_pkg::*;
#(
    parameter int MaxEarlyBeats  = 64,
    parameter int AddrQueueDepth = 8,
    parameter int BurstLenW      = SIMMEM_BURST_LEN_W,
    parameter int IidW           = SIMMEM_IID_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 waddr_valid_i,
    output logic                 waddr_ready_o,
    input  logic [BurstLenW-1:0] waddr_burst_len_i,
    input  logic [IidW-1:0]      waddr_iid_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    output logic                 core_waddr_valid_o,
    input  logic                 core_waddr_ready_i,
    output logic [IidW-1:0]      core_waddr_iid_o,
    output logic [BurstLenW:0]   core_waddr_len_o,
    output logic [BurstLenW:0]   core_wdata_immediate_cnt_o,
    output logic                 core_wdata_valid_o,
    output logic [IidW-1:0]      core_wdata_iid_o,
    output logic                 core_wdata_last_o,
    output logic [15:0]          wdata_stall_cnt_o
);

    localparam int EARLY_W = $clog2(MaxEarlyBeats + 1);
    localparam int CNT_W   = (EARLY_W > BurstLenW + 1) ? EARLY_W : BurstLenW + 1;
    localparam logic [EARLY_W-1:0]   MAX_EARLY = EARLY_W'(MaxEarlyBeats);
    localparam logic [BurstLenW:0]   REM_ONE   = (BurstLenW + 1)'(1);

    logic [EARLY_W-1:0] early_q;
    logic [EARLY_W-1:0] early_d;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    wdata_pend_t        w_head;
    wdata_pend_t        w_push_data;
    logic               w_push;
    logic               w_pop;

    logic               w_waddr_acc;
    logic               w_wdata_acc;
    logic               w_fwd;
    logic               w_early_beat;
    logic [BurstLenW:0] w_len;
    logic [CNT_W-1:0]   w_len_ext;
    logic [CNT_W-1:0]   w_e;
    logic [CNT_W-1:0]   w_imm_ext;
    logic               w_head_last;

    // Handshakes: a full queue blocks only addresses; data is blocked only
    // when no burst is pending and the early counter is saturated.
    assign waddr_ready_o      = !rst_i && core_waddr_ready_i && !w_fifo_full;
    assign core_waddr_valid_o = !rst_i && waddr_valid_i && !w_fifo_full;
    assign wdata_ready_o      = !rst_i && (!w_fifo_empty || (early_q < MAX_EARLY));

    assign w_waddr_acc  = waddr_valid_i && waddr_ready_o;
    assign w_wdata_acc  = wdata_valid_i && wdata_ready_o;
    assign w_fwd        = w_wdata_acc && !w_fifo_empty;
    assign w_early_beat = w_wdata_acc && w_fifo_empty;

    // Early beats seen so far, including one arriving this very cycle.
    assign w_len     = get_effective_burst_len(waddr_burst_len_i);
    assign w_len_ext = CNT_W'(w_len);
    assign w_e       = CNT_W'(early_q) + CNT_W'(w_early_beat);
    assign w_imm_ext = (w_e < w_len_ext) ? w_e : w_len_ext;

    assign w_head_last = (w_head.remaining == REM_ONE);

    assign w_push                = w_waddr_acc && (w_len_ext > w_e);
    assign w_push_data.iid       = waddr_iid_i;
    assign w_push_data.remaining = BurstLenW'(0) + (w_len - w_imm_ext[BurstLenW:0]);
    assign w_pop                 = w_fwd && w_head_last;

    assign core_waddr_iid_o           = waddr_iid_i;
    assign core_waddr_len_o           = w_len;
    assign core_wdata_immediate_cnt_o = w_imm_ext[BurstLenW:0];
    assign core_wdata_valid_o         = w_fwd;
    assign core_wdata_iid_o           = w_head.iid;
    assign core_wdata_last_o          = w_fwd && w_head_last;

    // Next early count: an accepted address absorbs as many held beats as it needs.
    always_comb begin
        early_d = EARLY_W'(w_e);
        if (w_waddr_acc) begin
            early_d = EARLY_W'(w_e - w_imm_ext);
        end
    end

    // Early-beat counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            early_q <= '0;
        end else begin
            early_q <= early_d;
        end
    end

    simmem_wdata_pend_fifo #(
        .Depth (AddrQueueDepth)
    ) u_pend_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .dec_i       (w_fwd),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

`ifdef SIMMEM_WDATA_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where the requester offered data we refused.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (wdata_valid_i && !wdata_ready_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign wdata_stall_cnt_o = stall_cnt_q;
`else
    assign wdata_stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simmem_wdata_binder.sv
// ============================================================================
// Module      : tb_simmem_wdata_binder
// Description : Directed self-checking bench for simmem_wdata_binder.
//               Honours SIMMEM_WDATA_STALL_CNT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simmem_wdata_binder;

    logic        clk;
    logic        rst;
    logic        waddr_valid;
    logic        waddr_ready;
    logic [7:0]  waddr_burst_len;
    logic [2:0]  waddr_iid;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        core_waddr_valid;
    logic        core_waddr_ready;
    logic [2:0]  core_waddr_iid;
    logic [8:0]  core_waddr_len;
    logic [8:0]  core_wdata_imm;
    logic        core_wdata_valid;
    logic [2:0]  core_wdata_iid;
    logic        core_wdata_last;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_errors;

    simmem_wdata_binder u_dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .waddr_valid_i              (waddr_valid),
        .waddr_ready_o              (waddr_ready),
        .waddr_burst_len_i          (waddr_burst_len),
        .waddr_iid_i                (waddr_iid),
        .wdata_valid_i              (wdata_valid),
        .wdata_ready_o              (wdata_ready),
        .core_waddr_valid_o         (core_waddr_valid),
        .core_waddr_ready_i         (core_waddr_ready),
        .core_waddr_iid_o           (core_waddr_iid),
        .core_waddr_len_o           (core_waddr_len),
        .core_wdata_immediate_cnt_o (core_wdata_imm),
        .core_wdata_valid_o         (core_wdata_valid),
        .core_wdata_iid_o           (core_wdata_iid),
        .core_wdata_last_o          (core_wdata_last),
        .wdata_stall_cnt_o          (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then let combinational outputs settle.
    task automatic drive(input logic av, input logic [7:0] len, input logic [2:0] iid, input logic dv);
        waddr_valid     = av;
        waddr_burst_len = len;
        waddr_iid       = iid;
        wdata_valid     = dv;
        #1;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        core_waddr_ready = 1'b1;
        drive(1'b1, 8'd0, 3'd0, 1'b1);
        tick();
        tick();
        // Reset: every handshake output held low.
        check("rst_waddr_ready", waddr_ready, 0);
        check("rst_wdata_ready", wdata_ready, 0);
        check("rst_core_waddr_valid", core_waddr_valid, 0);
        check("rst_core_wdata_valid", core_wdata_valid, 0);
        rst = 1'b0;
        drive(1'b0, 8'd0, 3'd0, 1'b0);
        check("post_rst_wdata_ready", wdata_ready, 1);
        check("post_rst_waddr_ready", waddr_ready, 1);
        check("post_rst_imm", core_wdata_imm, 0);
        tick();

        // 1) Address len=3, no data held -> imm 0, then four forwarded beats.
        drive(1'b1, 8'd3, 3'd5, 1'b0);
        check("t1_core_waddr_valid", core_waddr_valid, 1);
        check("t1_len", core_waddr_len, 4);
        check("t1_iid", core_waddr_iid, 5);
        check("t1_imm", core_wdata_imm, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'd0, 3'd0, 1'b1);
            check("t1_beat_valid", core_wdata_valid, 1);
            check("t1_beat_iid", core_wdata_iid, 5);
            check("t1_beat_last", core_wdata_last, (k == 3) ? 1 : 0);
            tick();
        end

        // 2) Six early beats, then len=3 (imm 4) and len=1 (imm 2).
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 8'd0, 3'd0, 1'b1);
            check("t2_early_not_fwd", core_wdata_valid, 0);
            tick();
        end
        drive(1'b1, 8'd3, 3'd2, 1'b0);
        check("t2_imm4", core_wdata_imm, 4);
        tick();
        drive(1'b1, 8'd1, 3'd3, 1'b0);
        check("t2_imm2", core_wdata_imm, 2);
        tick();

        // 3) Address len=0 with a same-cycle beat -> imm 1, nothing forwarded or pushed.
        drive(1'b1, 8'd0, 3'd4, 1'b1);
        check("t3_imm1", core_wdata_imm, 1);
        check("t3_no_fwd", core_wdata_valid, 0);
        tick();
        drive(1'b0, 8'd0, 3'd0, 1'b1);
        check("t3_queue_empty", core_wdata_valid, 0);
        tick();
        drive(1'b0, 8'd7, 3'd0, 1'b0);
        check("t3_early_was_zero", core_wdata_imm, 1);
        drive(1'b1, 8'd0, 3'd1, 1'b0);
        check("t3_drain_imm", core_wdata_imm, 1);
        tick();

        // 4) Fill the early counter to 64, stall once, then absorb 8.
        for (int k = 0; k < 64; k++) begin
            drive(1'b0, 8'd0, 3'd0, 1'b1);
            if (k == 63) check("t4_ready_last_slot", wdata_ready, 1);
            tick();
        end
        drive(1'b0, 8'd0, 3'd0, 1'b1);
        check("t4_full_stall", wdata_ready, 0);
        tick();
        drive(1'b1, 8'd7, 3'd6, 1'b0);
        check("t4_imm8", core_wdata_imm, 8);
        tick();
        drive(1'b0, 8'd255, 3'd0, 1'b0);
        check("t4_ready_back", wdata_ready, 1);
        check("t4_early56", core_wdata_imm, 56);
`ifdef SIMMEM_WDATA_STALL_CNT_EN
        check("t4_stall_cnt", stall_cnt, 1);
`else
        check("t4_stall_cnt_tied", stall_cnt, 0);
`endif
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 8'd7, 3'd6, 1'b0);
            check("t4_drain_imm8", core_wdata_imm, 8);
            tick();
        end
        drive(1'b0, 8'd255, 3'd0, 1'b0);
        check("t4_early0", core_wdata_imm, 0);

        // 5) Eight zero-length-plus-one bursts fill the queue; one beat frees a slot.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'd0, 3'(k), 1'b0);
            check("t5_fill_ready", waddr_ready, 1);
            tick();
        end
        drive(1'b1, 8'd0, 3'd0, 1'b1);
        check("t5_full_waddr_ready", waddr_ready, 0);
        check("t5_full_core_valid", core_waddr_valid, 0);
        check("t5_pop_valid", core_wdata_valid, 1);
        check("t5_pop_iid", core_wdata_iid, 0);
        check("t5_pop_last", core_wdata_last, 1);
        tick();
        drive(1'b1, 8'd0, 3'd0, 1'b0);
        check("t5_slot_freed", waddr_ready, 1);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 8'd0, 3'd0, 1'b1);
            check("t5_order_iid", core_wdata_iid, k % 8);
            check("t5_order_last", core_wdata_last, 1);
            tick();
        end

        // 6) Reset in the middle of a burst with two beats still owed.
        drive(1'b1, 8'd3, 3'd6, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 8'd0, 3'd0, 1'b1);
            check("t6_mid_last", core_wdata_last, 0);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, 8'd0, 3'd0, 1'b1);
        check("t6_rst_wdata_ready", wdata_ready, 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'd7, 3'd0, 1'b0);
        check("t6_early_cleared", core_wdata_imm, 0);
        check("t6_waddr_ready", waddr_ready, 1);
`ifdef SIMMEM_WDATA_STALL_CNT_EN
        check("t6_stall_cleared", stall_cnt, 0);
`else
        check("t6_stall_tied", stall_cnt, 0);
`endif
        drive(1'b0, 8'd0, 3'd0, 1'b1);
        check("t6_fifo_cleared", core_wdata_valid, 0);
        tick();
        drive(1'b0, 8'd0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
